// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin flag scheduler: sizes, state encoding
// and the one-hot grant helper.
package rr_sched_pkg;

  localparam int N      = 16;
  localparam int IDW    = 4;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    GRANT   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_hold_timer.sv
// Grant hold timer: counts cycles while a grant is active and flags the cycle
// in which the hold limit is reached.
module rr_hold_timer
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  output logic [HOLD_W-1:0] count,
  output logic              expire
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  // Saturating cycle counter; cleared whenever no grant is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= {HOLD_W{1'b0}};
    end else if (clear) begin
      count <= {HOLD_W{1'b0}};
    end else if (enable && (count != {HOLD_W{1'b1}})) begin
      count <= count + {{(HOLD_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign expire = enable && (count == LIMIT);

endmodule

// File: rtl/rr_flag_scheduler.sv
// Round-robin scheduler: snapshots the request flags, scans one bit per clock
// after the last-served index and holds a one-hot grant until released.
module rr_flag_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           busy,
  output logic           timeout
);

  state_t              state, state_nxt;
  logic [N-1:0]        req_q, req_q_nxt;
  logic [IDW-1:0]      idx, idx_nxt;
  logic [IDW-1:0]      cnt, cnt_nxt;
  logic [IDW-1:0]      ptr, ptr_nxt;
  logic [N-1:0]        gnt_nxt;
  logic [IDW-1:0]      gnt_id_nxt;
  logic                gnt_valid_nxt;
  logic                busy_nxt;
  logic                timeout_nxt;
  logic [HOLD_W-1:0]   hold;
  logic                expire;

  rr_hold_timer #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (state != GRANT),
    .enable(state == GRANT),
    .count (hold),
    .expire(expire)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_q     <= {N{1'b0}};
      idx       <= {IDW{1'b0}};
      cnt       <= {IDW{1'b0}};
      ptr       <= {IDW{1'b0}};
      gnt       <= {N{1'b0}};
      gnt_id    <= {IDW{1'b0}};
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req_q_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= gnt_id_nxt;
      gnt_valid <= gnt_valid_nxt;
      busy      <= busy_nxt;
      timeout   <= timeout_nxt;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nxt     = state;
    req_q_nxt     = req_q;
    idx_nxt       = idx;
    cnt_nxt       = cnt;
    ptr_nxt       = ptr;
    gnt_nxt       = gnt;
    gnt_id_nxt    = gnt_id;
    gnt_valid_nxt = gnt_valid;
    busy_nxt      = busy;
    timeout_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          req_q_nxt = req;
          idx_nxt   = ptr;
          cnt_nxt   = {IDW{1'b0}};
          busy_nxt  = 1'b1;
          state_nxt = SCAN;
        end else begin
          state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (req_q[idx]) begin
          gnt_id_nxt    = idx;
          gnt_nxt       = onehot(idx);
          gnt_valid_nxt = 1'b1;
          state_nxt     = GRANT;
        end else begin
          idx_nxt = idx + 4'd1;
          cnt_nxt = cnt + 4'd1;
          // Guard for an empty snapshot; a nonzero snapshot always hits first.
          if (cnt == 4'd15) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            state_nxt = SCAN;
          end
        end
      end
      GRANT: begin
        if (done || !req[gnt_id] || expire) begin
          gnt_nxt       = {N{1'b0}};
          gnt_valid_nxt = 1'b0;
          busy_nxt      = 1'b0;
          ptr_nxt       = gnt_id + 4'd1;
          timeout_nxt   = !done && req[gnt_id] && expire;
          state_nxt     = IDLE;
        end else begin
          state_nxt = GRANT;
        end
      end
      default: begin
        gnt_nxt       = {N{1'b0}};
        gnt_valid_nxt = 1'b0;
        busy_nxt      = 1'b0;
        state_nxt     = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_flag_scheduler.sv
// Directed bench for rr_flag_scheduler: a table of grant scenarios applied in
// order, followed by timeout, done-vs-timeout and asynchronous reset sequences.
module tb_rr_flag_scheduler;
  import rr_sched_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           busy;
  logic           timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_flag_scheduler #(.MAX_HOLD(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .gnt_valid(gnt_valid),
    .busy     (busy),
    .timeout  (timeout)
  );

  typedef struct {
    logic [15:0] req;
    logic [3:0]  id;
    int          lat;
    bit          drop;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts negedges (each containing one posedge) until gnt_valid is seen.
  task automatic wait_grant(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt_valid && lat < 40);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'h0);
    check({tag, "_valid"}, 32'(gnt_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_timeout"}, 32'(timeout), 32'h0);
  endtask

  initial begin
    int          lat;
    int          n;
    logic [15:0] exp_gnt;

    // Expected ids and latencies follow the pointer from reset (ptr=0).
    vecs[0] = '{16'h2000, 4'd13, 15, 1'b0};  // ptr 0 -> 14
    vecs[1] = '{16'h0005, 4'd0,  4,  1'b0};  // ptr 14 -> 1
    vecs[2] = '{16'h0005, 4'd2,  3,  1'b0};  // ptr 1 -> 3
    vecs[3] = '{16'h0005, 4'd0,  15, 1'b0};  // ptr 3 -> 1
    vecs[4] = '{16'h0005, 4'd2,  3,  1'b0};  // ptr 1 -> 3
    vecs[5] = '{16'h8000, 4'd15, 14, 1'b0};  // ptr 3 -> 0 (wrap)
    vecs[6] = '{16'h8002, 4'd1,  3,  1'b0};  // ptr 0 -> 2
    vecs[7] = '{16'hFFFF, 4'd2,  2,  1'b0};  // ptr 2 -> 3
    vecs[8] = '{16'h0008, 4'd3,  2,  1'b1};  // ptr 3 -> 4, released by drop

    rst  = 1'b1;
    req  = 16'h0000;
    done = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_gnt_id", 32'(gnt_id), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      req = vecs[i].req;
      wait_grant(lat);
      exp_gnt = 16'd1 << vecs[i].id;
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_gnt_id", i), 32'(gnt_id), 32'(vecs[i].id));
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(exp_gnt));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      if (vecs[i].drop) begin
        req = 16'h0000;
        @(negedge clk);
      end else begin
        repeat (2) @(negedge clk);
        check($sformatf("v%0d_held", i), 32'(gnt_valid), 32'h1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        req  = 16'h0000;
      end
      check_idle_outputs($sformatf("v%0d_rel", i));
      check($sformatf("v%0d_id_kept", i), 32'(gnt_id), 32'(vecs[i].id));
    end

    // Hold timeout with the request held: 8 grant cycles, then a pulse.
    req = 16'h0010;
    wait_grant(lat);
    check("to_latency", 32'(lat), 32'd2);
    check("to_gnt_id", 32'(gnt_id), 32'd4);
    n = 0;
    while (gnt_valid && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_hold_cycles", 32'(n), 32'd8);
    check("to_pulse", 32'(timeout), 32'h1);
    check("to_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    check("to_pulse_end", 32'(timeout), 32'h0);
    wait_grant(lat);
    check("to_regrant_latency", 32'(lat + 1), 32'd17);
    check("to_regrant_id", 32'(gnt_id), 32'd4);

    // done in the expiring cycle is a normal release without a pulse.
    repeat (7) @(negedge clk);
    check("dt_held", 32'(gnt_valid), 32'h1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 16'h0000;
    check("dt_valid", 32'(gnt_valid), 32'h0);
    check("dt_timeout", 32'(timeout), 32'h0);

    // Asynchronous reset mid-SCAN (ptr is 5 here).
    req = 16'h2000;
    repeat (3) @(negedge clk);
    check("ms_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("ms_rst");
    @(negedge clk);
    rst = 1'b0;
    req = 16'h0021;
    wait_grant(lat);
    check("ms_latency", 32'(lat), 32'd2);
    check("ms_gnt_id", 32'(gnt_id), 32'd0);

    // Asynchronous reset mid-GRANT.
    #2 rst = 1'b1;
    #1 check_idle_outputs("mg_rst");
    check("mg_gnt_id", 32'(gnt_id), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 16'h0001;
    wait_grant(lat);
    check("mg_latency", 32'(lat), 32'd2);
    check("mg_gnt_id2", 32'(gnt_id), 32'd0);
    check("mg_gnt", 32'(gnt), 32'h1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    req  = 16'h0000;
    check_idle_outputs("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
